// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a 2-FF input synchronizer.
// Each correctly framed byte is presented on rx_data with a one-cycle
// data_valid strobe. A low stop bit gives a one-cycle framing_error pulse,
// after which the receiver waits for the line to return high.
// status_leds mirrors the low DATA_WIDTH bits of the last good byte.
module uart_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  output logic [7:0]            rx_data,
  output logic                  data_valid,
  output logic                  framing_error,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] status_leds
);

  // Bit period and half bit period, both expressed as terminal counts.
  localparam int          P_CYC = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] P_M1  = 16'(P_CYC - 1);
  localparam logic [15:0] H_M1  = 16'((P_CYC / 2) - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_e;

  logic                  sync1_q;
  logic                  rx_s_q;
  state_e                state_q,   state_d;
  logic [15:0]           cnt_q,     cnt_d;
  logic [2:0]            idx_q,     idx_d;
  logic [7:0]            shift_q,   shift_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  valid_q,   valid_d;
  logic                  ferr_q,    ferr_d;
  logic                  busy_q,    busy_d;
  logic [DATA_WIDTH-1:0] leds_q,    leds_d;

  // Next-state logic: baud counting, bit sampling and output strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    leds_d    = leds_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (!rx_s_q) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // Mid-start-bit check rejects short glitches on the line.
        if (cnt_q == H_M1) begin
          cnt_d = 16'd0;
          idx_d = 3'd0;
          if (!rx_s_q) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        // Shifting in from the top leaves the first (LSB) bit at bit 0.
        if (cnt_q == P_M1) begin
          cnt_d   = 16'd0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == P_M1) begin
          cnt_d = 16'd0;
          if (rx_s_q) begin
            rx_data_d = shift_q;
            leds_d    = shift_q[DATA_WIDTH-1:0];
            valid_d   = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low line (break) reports only one error.
        cnt_d = 16'd0;
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, synchronizer and registered outputs; synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      idx_q     <= 3'd0;
      shift_q   <= 8'd0;
      rx_data_q <= 8'd0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
      leds_q    <= '0;
    end else begin
      sync1_q   <= rx_in;
      rx_s_q    <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
      leds_q    <= leds_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign busy          = busy_q;
  assign status_leds   = leds_q;

endmodule
